// File: rtl/display_write_scheduler.sv
// Two-port register-write arbiter in front of the display block.
// Spaces toggle-class writes so the pixel-clock toggle syncs never drop one.
module display_write_scheduler #(
   parameter int unsigned GAP_CYCLES = 40,
   parameter int unsigned STALL_W    = 16
) (
   input  logic               clk_74a,
   input  logic               reset_n,
   input  logic               p0_valid_i,
   output logic               p0_ready_o,
   input  logic [31:0]        p0_addr_i,
   input  logic [31:0]        p0_data_i,
   input  logic               p1_valid_i,
   output logic               p1_ready_o,
   input  logic [31:0]        p1_addr_i,
   input  logic [31:0]        p1_data_i,
   output logic [31:0]        disp_addr_o,
   output logic               disp_wr_o,
   output logic [31:0]        disp_wr_data_o,
   output logic               last_grant_o,
   output logic               gap_busy_o,
   output logic [STALL_W-1:0] stall_cnt_o
);

   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   function automatic logic is_toggle(input logic [31:0] a);
      return (a == 32'h0020_0000) || (a == 32'h0020_0004) ||
             (a == 32'h00F0_0010) || (a == 32'h00F0_0014) ||
             (a == 32'h00F0_0018);
   endfunction

   logic [GW-1:0]      gap_q, gap_d;
   logic               gap_busy_q, gap_busy_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               rr_q, rr_d;
   logic               last_q, last_d;
   logic               wr_q, wr_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        data_q, data_d;

   logic tog0, tog1, gap_zero;
   logic elig0, elig1;
   logic gnt0, gnt1, gnt_any, gnt_tog;
   logic stall_now;

   // Classify each port's head request and decide who may go this cycle.
   always_comb begin
      tog0     = is_toggle(p0_addr_i);
      tog1     = is_toggle(p1_addr_i);
      gap_zero = (gap_q == '0);
      elig0    = p0_valid_i & (~tog0 | gap_zero);
      elig1    = p1_valid_i & (~tog1 | gap_zero);
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (elig0 && elig1) begin
         gnt0 = ~rr_q;
         gnt1 = rr_q;
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
      gnt_any   = gnt0 | gnt1;
      gnt_tog   = (gnt0 & tog0) | (gnt1 & tog1);
      stall_now = ((p0_valid_i & tog0) | (p1_valid_i & tog1)) & ~gap_zero;
   end

   // Readies are held low while reset is asserted.
   always_comb begin
      p0_ready_o = gnt0 & reset_n;
      p1_ready_o = gnt1 & reset_n;
   end

   // Next-state for issue register, round-robin pointer, gap and stall count.
   always_comb begin
      wr_d       = gnt_any;
      addr_d     = addr_q;
      data_d     = data_q;
      last_d     = last_q;
      rr_d       = rr_q;
      gap_d      = gap_q;
      stall_d    = stall_q;
      if (gnt0) begin
         addr_d = p0_addr_i;
         data_d = p0_data_i;
         last_d = 1'b0;
         rr_d   = 1'b1;
      end else if (gnt1) begin
         addr_d = p1_addr_i;
         data_d = p1_data_i;
         last_d = 1'b1;
         rr_d   = 1'b0;
      end
      if (gnt_tog) begin
         gap_d = GAP_LOAD;
      end else if (!gap_zero) begin
         gap_d = gap_q - 1'b1;
      end
      gap_busy_d = (gap_d != '0);
      if (stall_now && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // State registers; async active-low reset clears everything.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         rr_q       <= 1'b0;
         gap_q      <= '0;
         gap_busy_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_q     <= last_d;
         rr_q       <= rr_d;
         gap_q      <= gap_d;
         gap_busy_q <= gap_busy_d;
         stall_q    <= stall_d;
      end
   end

   assign disp_wr_o      = wr_q;
   assign disp_addr_o    = addr_q;
   assign disp_wr_data_o = data_q;
   assign last_grant_o   = last_q;
   assign gap_busy_o     = gap_busy_q;
   assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_display_write_scheduler.sv
// Directed bench for display_write_scheduler.
// Second instance with a 4-bit stall counter checks saturation.
module tb_display_write_scheduler;

   logic        clk_74a = 1'b0;
   logic        reset_n = 1'b0;
   logic        p0_valid = 1'b0, p1_valid = 1'b0;
   logic [31:0] p0_addr = '0, p0_data = '0, p1_addr = '0, p1_data = '0;

   logic        p0_ready, p1_ready, disp_wr, last_grant, gap_busy;
   logic [31:0] disp_addr, disp_wr_data;
   logic [15:0] stall_cnt;

   logic        p0_ready4, p1_ready4, disp_wr4, last_grant4, gap_busy4;
   logic [31:0] disp_addr4, disp_wr_data4;
   logic [3:0]  stall_cnt4;

   int tests = 0;
   int fails = 0;

   always #5 clk_74a = ~clk_74a;

   display_write_scheduler #(.GAP_CYCLES(40), .STALL_W(16)) dut (
      .clk_74a(clk_74a), .reset_n(reset_n),
      .p0_valid_i(p0_valid), .p0_ready_o(p0_ready),
      .p0_addr_i(p0_addr), .p0_data_i(p0_data),
      .p1_valid_i(p1_valid), .p1_ready_o(p1_ready),
      .p1_addr_i(p1_addr), .p1_data_i(p1_data),
      .disp_addr_o(disp_addr), .disp_wr_o(disp_wr),
      .disp_wr_data_o(disp_wr_data), .last_grant_o(last_grant),
      .gap_busy_o(gap_busy), .stall_cnt_o(stall_cnt)
   );

   display_write_scheduler #(.GAP_CYCLES(40), .STALL_W(4)) dut4 (
      .clk_74a(clk_74a), .reset_n(reset_n),
      .p0_valid_i(p0_valid), .p0_ready_o(p0_ready4),
      .p0_addr_i(p0_addr), .p0_data_i(p0_data),
      .p1_valid_i(p1_valid), .p1_ready_o(p1_ready4),
      .p1_addr_i(p1_addr), .p1_data_i(p1_data),
      .disp_addr_o(disp_addr4), .disp_wr_o(disp_wr4),
      .disp_wr_data_o(disp_wr_data4), .last_grant_o(last_grant4),
      .gap_busy_o(gap_busy4), .stall_cnt_o(stall_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_74a);
      #1;
   endtask

   initial begin
      int n, gb, wrs;
      logic [31:0] d0, d1;
      logic exp_port;

      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
      chk("rst_wr", disp_wr, 0);
      chk("rst_stall", stall_cnt, 0);

      // Back-to-back toggle writes on port 0.
      p0_valid = 1'b1; p0_addr = 32'h0020_0000; p0_data = 32'h64;
      #1;
      chk("t2_rdy0", p0_ready, 1);
      step();
      chk("t2_wr1", disp_wr, 1);
      chk("t2_addr1", disp_addr, 32'h0020_0000);
      chk("t2_data1", disp_wr_data, 32'h64);
      p0_addr = 32'h0020_0004; p0_data = 32'h20;
      #1;
      chk("t2_rdy_blk", p0_ready, 0);
      n = 0; gb = 0; wrs = 0;
      while (!p0_ready && n < 100) begin
         if (gap_busy) gb++;
         step();
         if (disp_wr) wrs++;
         n++;
      end
      chk("t2_wait", n, 39);
      chk("t2_gapbusy", gb, 39);
      chk("t2_nowr", wrs, 0);
      step();
      p0_valid = 1'b0;
      chk("t2_wr2", disp_wr, 1);
      chk("t2_addr2", disp_addr, 32'h0020_0004);
      chk("t2_data2", disp_wr_data, 32'h20);
      chk("t2_stall", stall_cnt, 39);
      chk("t6_sat_a", stall_cnt4, 15);

      // Level write on port 1 overtakes a gap-blocked port 0 toggle.
      p0_valid = 1'b1; p0_addr = 32'h00F0_0010; p0_data = 32'h1;
      p1_valid = 1'b1; p1_addr = 32'h00F0_000C; p1_data = 32'h3;
      #1;
      chk("t3_rdy0", p0_ready, 0);
      chk("t3_rdy1", p1_ready, 1);
      step();
      p1_valid = 1'b0;
      chk("t3_wr1", disp_wr, 1);
      chk("t3_addr1", disp_addr, 32'h00F0_000C);
      chk("t3_data1", disp_wr_data, 32'h3);
      chk("t3_lg1", last_grant, 1);
      n = 0; wrs = 0;
      while (!p0_ready && n < 100) begin
         step();
         if (disp_wr) wrs++;
         n++;
      end
      chk("t3_wait", n, 38);
      chk("t3_nowr", wrs, 0);
      step();
      chk("t3_wr0", disp_wr, 1);
      chk("t3_addr0", disp_addr, 32'h00F0_0010);
      chk("t3_lg0", last_grant, 0);

      // Reset mid-traffic: outputs clear at once, readies low.
      p0_addr = 32'h0010_0004; d0 = 32'h100; p0_data = d0;
      p1_valid = 1'b1; p1_addr = 32'h0010_0004; d1 = 32'h200; p1_data = d1;
      #1;
      reset_n = 1'b0;
      #1;
      chk("t1_wr", disp_wr, 0);
      chk("t1_addr", disp_addr, 0);
      chk("t1_data", disp_wr_data, 0);
      chk("t1_lg", last_grant, 0);
      chk("t1_gb", gap_busy, 0);
      chk("t1_stall", stall_cnt, 0);
      chk("t1_rdy0", p0_ready, 0);
      chk("t1_rdy1", p1_ready, 0);
      step();
      reset_n = 1'b1;
      #1;

      // Both ports stream level writes: strict alternation from port 0.
      for (int i = 0; i < 6; i++) begin
         exp_port = i[0];
         chk("t4_rdy0", p0_ready, !exp_port);
         chk("t4_rdy1", p1_ready, exp_port);
         step();
         chk("t4_wr", disp_wr, 1);
         chk("t4_lg", last_grant, exp_port);
         chk("t4_data", disp_wr_data, exp_port ? d1 : d0);
         if (exp_port) begin
            d1 = d1 + 1; p1_data = d1;
         end else begin
            d0 = d0 + 1; p0_data = d0;
         end
         #1;
      end
      p0_valid = 1'b0; p1_valid = 1'b0;
      step();

      // Reset 10 cycles into a gap clears the wait.
      p0_valid = 1'b1; p0_addr = 32'h0020_0000;
      step();
      p0_valid = 1'b0;
      repeat (10) step();
      chk("t5_gb_pre", gap_busy, 1);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
      chk("t5_gb_post", gap_busy, 0);
      p1_valid = 1'b1; p1_addr = 32'h00F0_0018; p1_data = 32'h7;
      #1;
      chk("t5_rdy1", p1_ready, 1);
      step();
      chk("t5_wr", disp_wr, 1);
      chk("t5_addr", disp_addr, 32'h00F0_0018);
      chk("t5_lg", last_grant, 1);

      // Hold toggles on both ports through repeated gaps.
      p0_valid = 1'b1; p0_addr = 32'h0020_0000;
      p1_addr = 32'h0020_0004;
      wrs = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (disp_wr) wrs++;
      end
      chk("t6_wrs", wrs, 2);
      chk("t6_stall16", stall_cnt, 98);
      chk("t6_sat", stall_cnt4, 15);
      p0_valid = 1'b0; p1_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
